irq_controller: RTL and testbench
=================================

IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 Parameter VECTOR_BASE, default 8'h08: base of the vector number presented to the CPU.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 bus_write  input  1  register write strobe, sampled on posedge clk.
REQ-005 bus_read  input  1  register read strobe; no side effects.
REQ-006 bus_address_in  input  24  register address.
REQ-007 bus_data_in  input  8  write data.
REQ-008 bus_data_out  output  8  read data, combinational from bus_address_in; 8'h00 for unmapped addresses.
REQ-009 irq_in  input  16  peripheral interrupt sources; 1 in any cycle means an event (the timer drives bits [2:0]).
REQ-010 cpu_irq_mask  input  2  current CPU interrupt priority level.
REQ-011 cpu_irq  output  1  interrupt request to the CPU.
REQ-012 cpu_irq_vector  output  8  vector for the request; stable while cpu_irq=1.
REQ-013 cpu_irq_ack  input  1  one-cycle acknowledge from the CPU.

Function
REQ-014 Register map:
- 0x2020: group priority, 2 bits per group; group g = sources 4g..4g+3 and occupies bits [2g+1:2g].
- 0x2023: enable[7:0]; 0x2024: enable[15:8].
- 0x2027: active[7:0]; 0x2028: active[15:8].
- All registers read back as stored.
REQ-015 Writing 0x2020, 0x2023 or 0x2024 stores bus_data_in on the posedge where bus_write=1.
REQ-016 Active flags are write-1-to-clear: a written 1 clears that bit; a written 0 has no effect.
REQ-017 irq_in[i]=1 sets active[i] on the next posedge, regardless of the enable bit.
REQ-018 When irq_in[i] and a write-1-to-clear of bit i occur in the same cycle, the set wins.
REQ-019 Source i is eligible when active[i]=1, enable[i]=1 and its group priority is nonzero (priority 0 disables the group).
REQ-020 Arbitration selects the eligible source with the highest group priority; ties go to the lowest source index.
REQ-021 A request is raised only if the selected priority is strictly greater than cpu_irq_mask.
REQ-022 cpu_irq_vector = VECTOR_BASE + 2*index, 8-bit modulo arithmetic.
REQ-023 FSM states: IDLE, REQ, ACK.
- IDLE -> REQ when a qualifying source exists; the vector and index are registered on this transition.
- REQ: cpu_irq=1 and the vector is held. There is no re-arbitration, even if a higher-priority source becomes eligible.
- REQ -> ACK on cpu_irq_ack=1.
- REQ -> IDLE (request withdrawn, cpu_irq drops next cycle) if the latched source stops being eligible or its priority is no longer greater than cpu_irq_mask.
- ACK -> IDLE after exactly one cycle, with cpu_irq=0.
REQ-024 cpu_irq_ack has no effect outside REQ.
REQ-025 Acknowledge does not clear the active flag; software clears it.
REQ-026 Latency: irq_in pulse at edge N sets active at edge N+1, and cpu_irq=1 from edge N+2.
REQ-027 cpu_irq is a registered output, equal to (state==REQ).

Reset
REQ-028 Reset clears priority, enable, active, the latched vector/index and cpu_irq, and sets the FSM to IDLE. cpu_irq_vector resets to 8'h00.
REQ-029 Reset asserted mid-request drops cpu_irq on the next posedge; irq_in is ignored while reset=1.
REQ-030 Reset has priority over bus writes and irq_in.

Structure
REQ-031 Shared package irq_pkg holds:
- NUM_IRQ=16 and NUM_GROUPS=4;
- register address constants;
- the FSM state enum.
REQ-032 One sub-module, irq_arbiter: combinational priority/index encoder taking eligible[15:0] and priority[7:0], returning valid, index[3:0] and prio[1:0].

Verification
REQ-033 Setup: priority=8'h03, enable=16'h0001, mask=0. Pulse irq_in[0] -> cpu_irq=1 two edges later, vector=8'h08; ack -> cpu_irq=0 for 1 cycle; without clearing, the request re-raises.
REQ-034 Tie-break: priority=8'hFF, enable=16'hFFFF. Pulse irq_in[5] and irq_in[2] simultaneously -> vector=8'h0C (index 2).
REQ-035 Group priority: group0=1, group3=3, mask=0. Pulse irq_in[1] and irq_in[13] together -> vector=8'h22. Then set mask=3 -> request withdrawn, cpu_irq=0.
REQ-036 Write-1-to-clear: write 8'h01 to 0x2027 in the same cycle as irq_in[0]=1 -> active[0] stays 1. Write 8'h01 alone -> active[0]=0 and the 0x2027 read returns 8'h00.
REQ-037 Reset mid-request: reset while in REQ -> cpu_irq=0, all registers read 8'h00, FSM IDLE.
REQ-038 Disabled source: enable=0. Pulse irq_in[3] -> the 0x2027 read returns 8'h08 and cpu_irq stays 0.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, register map and FSM state type for the interrupt controller
package irq_pkg;

    localparam int NUM_IRQ    = 16;
    localparam int NUM_GROUPS = 4;

    localparam logic [23:0] ADDR_PRIORITY  = 24'h002020;
    localparam logic [23:0] ADDR_ENABLE_LO = 24'h002023;
    localparam logic [23:0] ADDR_ENABLE_HI = 24'h002024;
    localparam logic [23:0] ADDR_ACTIVE_LO = 24'h002027;
    localparam logic [23:0] ADDR_ACTIVE_HI = 24'h002028;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK  = 2'd2
    } irq_state_t;

    // Source idx belongs to group idx/4, whose 2-bit priority sits at bits [2g+1:2g].
    function automatic logic [1:0] group_prio(input logic [7:0] prio_reg, input logic [3:0] idx);
        logic [2:0] lsb;
        lsb = {idx[3:2], 1'b0};
        return prio_reg[lsb +: 2];
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - register bus bundle between the CPU side and the interrupt controller
interface irq_controller_if;

    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;

    modport master (
        output bus_write,
        output bus_read,
        output bus_address_in,
        output bus_data_in,
        input  bus_data_out
    );

    modport slave (
        input  bus_write,
        input  bus_read,
        input  bus_address_in,
        input  bus_data_in,
        output bus_data_out
    );

endinterface

// File: rtl/irq_arbiter.sv
// rtl/irq_arbiter.sv - combinational highest-group-priority, lowest-index source selector
module irq_arbiter
    import irq_pkg::*;
(
    input  logic [NUM_IRQ-1:0] eligible,
    input  logic [7:0]         prio_reg,
    output logic               valid,
    output logic [3:0]         index,
    output logic [1:0]         prio
);

    // Ascending scan with a strict compare keeps the lowest index among equal priorities.
    always_comb begin
        valid = 1'b0;
        index = 4'd0;
        prio  = 2'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (eligible[i] && (!valid || (group_prio(prio_reg, 4'(i)) > prio))) begin
                valid = 1'b1;
                index = 4'(i);
                prio  = group_prio(prio_reg, 4'(i));
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - 16-source prioritised interrupt controller with register bus and CPU handshake
module irq_controller
    import irq_pkg::*;
#(
    parameter logic [7:0] VECTOR_BASE = 8'h08
) (
    input  logic                clk,
    input  logic                reset,
    irq_controller_if.slave     bus,
    input  logic [NUM_IRQ-1:0]  irq_in,
    input  logic [1:0]          cpu_irq_mask,
    output logic                cpu_irq,
    output logic [7:0]          cpu_irq_vector,
    input  logic                cpu_irq_ack
);

    logic [7:0]         prio_q;
    logic [15:0]        enable_q;
    logic [15:0]        active_q;
    logic [15:0]        active_d;
    logic [15:0]        clear_mask;
    logic [15:0]        eligible;
    logic [3:0]         idx_q;
    logic [7:0]         vec_q;
    logic               cpu_irq_q;
    irq_state_t         state_q;
    irq_state_t         state_d;
    logic               latch_req;
    logic               latched_ok;
    logic               arb_valid;
    logic [3:0]         arb_index;
    logic [1:0]         arb_prio;

    // Reads have no side effects, so the read strobe is not needed by the logic.
    logic unused_bus_read;
    assign unused_bus_read = bus.bus_read;

    logic wr_prio;
    logic wr_en_lo;
    logic wr_en_hi;
    logic wr_act_lo;
    logic wr_act_hi;

    assign wr_prio   = bus.bus_write && (bus.bus_address_in == ADDR_PRIORITY);
    assign wr_en_lo  = bus.bus_write && (bus.bus_address_in == ADDR_ENABLE_LO);
    assign wr_en_hi  = bus.bus_write && (bus.bus_address_in == ADDR_ENABLE_HI);
    assign wr_act_lo = bus.bus_write && (bus.bus_address_in == ADDR_ACTIVE_LO);
    assign wr_act_hi = bus.bus_write && (bus.bus_address_in == ADDR_ACTIVE_HI);

    // Write-1-to-clear first, then OR in new events so a same-cycle event wins over the clear.
    always_comb begin
        clear_mask = {wr_act_hi ? bus.bus_data_in : 8'h00,
                      wr_act_lo ? bus.bus_data_in : 8'h00};
        active_d   = (active_q & ~clear_mask) | irq_in;
    end

    // A source competes only when pending, enabled and its group is not switched off.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            eligible[i] = active_q[i] && enable_q[i] && (group_prio(prio_q, 4'(i)) != 2'd0);
        end
    end

    irq_arbiter u_arbiter (
        .eligible (eligible),
        .prio_reg (prio_q),
        .valid    (arb_valid),
        .index    (arb_index),
        .prio     (arb_prio)
    );

    // The request stays up only while the source captured at raise time still beats the mask.
    assign latched_ok = eligible[idx_q] && (group_prio(prio_q, idx_q) > cpu_irq_mask);

    // Next-state logic; no re-arbitration happens while a request is outstanding.
    always_comb begin
        state_d   = state_q;
        latch_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid && (arb_prio > cpu_irq_mask)) begin
                    state_d   = ST_REQ;
                    latch_req = 1'b1;
                end
            end
            ST_REQ: begin
                if (cpu_irq_ack) begin
                    state_d = ST_ACK;
                end else if (!latched_ok) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, registers and latched vector; reset overrides writes and events.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            prio_q    <= 8'h00;
            enable_q  <= 16'h0000;
            active_q  <= 16'h0000;
            idx_q     <= 4'd0;
            vec_q     <= 8'h00;
            cpu_irq_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            cpu_irq_q <= (state_d == ST_REQ);
            if (wr_prio) begin
                prio_q <= bus.bus_data_in;
            end
            if (wr_en_lo) begin
                enable_q[7:0] <= bus.bus_data_in;
            end
            if (wr_en_hi) begin
                enable_q[15:8] <= bus.bus_data_in;
            end
            if (latch_req) begin
                idx_q <= arb_index;
                vec_q <= VECTOR_BASE + {3'b000, arb_index, 1'b0};
            end
        end
    end

    assign cpu_irq        = cpu_irq_q;
    assign cpu_irq_vector = vec_q;

    // Read data decodes the full 24-bit address; anything unmapped reads as zero.
    always_comb begin
        bus.bus_data_out = 8'h00;
        case (bus.bus_address_in)
            ADDR_PRIORITY:  bus.bus_data_out = prio_q;
            ADDR_ENABLE_LO: bus.bus_data_out = enable_q[7:0];
            ADDR_ENABLE_HI: bus.bus_data_out = enable_q[15:8];
            ADDR_ACTIVE_LO: bus.bus_data_out = active_q[7:0];
            ADDR_ACTIVE_HI: bus.bus_data_out = active_q[15:8];
            default:        bus.bus_data_out = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - directed self-checking bench for irq_controller
module tb_irq_controller;

    logic        clk;
    logic        reset;
    logic [15:0] irq_in;
    logic [1:0]  cpu_irq_mask;
    logic        cpu_irq;
    logic [7:0]  cpu_irq_vector;
    logic        cpu_irq_ack;

    int n_cmp;
    int n_err;

    irq_controller_if bus_if ();

    irq_controller #(.VECTOR_BASE(8'h08)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus_if.slave),
        .irq_in         (irq_in),
        .cpu_irq_mask   (cpu_irq_mask),
        .cpu_irq        (cpu_irq),
        .cpu_irq_vector (cpu_irq_vector),
        .cpu_irq_ack    (cpu_irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [23:0] addr, input logic [7:0] data);
        bus_if.bus_address_in = addr;
        bus_if.bus_data_in    = data;
        bus_if.bus_write      = 1'b1;
        tick();
        bus_if.bus_write      = 1'b0;
    endtask

    task automatic bus_rd(input logic [23:0] addr, output logic [7:0] data);
        bus_if.bus_address_in = addr;
        bus_if.bus_read       = 1'b1;
        #1;
        data = bus_if.bus_data_out;
        bus_if.bus_read       = 1'b0;
    endtask

    task automatic pulse_irq(input logic [15:0] bits);
        irq_in = bits;
        tick();
        irq_in = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        logic [23:0] addrs [5];
        addrs = '{24'h002020, 24'h002023, 24'h002024, 24'h002027, 24'h002028};
        do_reset();
        n_cmp++;
        if (cpu_irq !== 1'b0) begin
            n_err++; $display("FAIL reset_cpu_irq: got %b want 0", cpu_irq);
        end
        n_cmp++;
        if (cpu_irq_vector !== 8'h00) begin
            n_err++; $display("FAIL reset_vector: got %h want 00", cpu_irq_vector);
        end
        foreach (addrs[k]) begin
            bus_rd(addrs[k], rd);
            n_cmp++;
            if (rd !== 8'h00) begin
                n_err++; $display("FAIL reset_reg_%h: got %h want 00", addrs[k], rd);
            end
        end
    endtask

    task automatic test_readback();
        logic [7:0] rd;
        do_reset();
        bus_wr(24'h002020, 8'hA5);
        bus_wr(24'h002023, 8'h3C);
        bus_wr(24'h002024, 8'hC3);
        bus_wr(24'h012020, 8'h77);
        bus_rd(24'h002020, rd);
        n_cmp++;
        if (rd !== 8'hA5) begin n_err++; $display("FAIL rb_prio: got %h want a5", rd); end
        bus_rd(24'h002023, rd);
        n_cmp++;
        if (rd !== 8'h3C) begin n_err++; $display("FAIL rb_en_lo: got %h want 3c", rd); end
        bus_rd(24'h002024, rd);
        n_cmp++;
        if (rd !== 8'hC3) begin n_err++; $display("FAIL rb_en_hi: got %h want c3", rd); end
        bus_rd(24'h002021, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL rb_unmapped: got %h want 00", rd); end
        bus_rd(24'h012020, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL rb_alias: got %h want 00", rd); end
    endtask

    task automatic test_basic_ack();
        logic [7:0] rd;
        bit raised;
        do_reset();
        cpu_irq_mask = 2'd0;
        bus_wr(24'h002020, 8'h03);
        bus_wr(24'h002023, 8'h01);
        bus_wr(24'h002024, 8'h00);
        pulse_irq(16'h0001);
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL basic_latency_early: got %b want 0", cpu_irq); end
        bus_rd(24'h002027, rd);
        n_cmp++;
        if (rd !== 8'h01) begin n_err++; $display("FAIL basic_active: got %h want 01", rd); end
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b1) begin n_err++; $display("FAIL basic_raise: got %b want 1", cpu_irq); end
        n_cmp++;
        if (cpu_irq_vector !== 8'h08) begin n_err++; $display("FAIL basic_vector: got %h want 08", cpu_irq_vector); end
        cpu_irq_ack = 1'b1;
        tick();
        cpu_irq_ack = 1'b0;
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL basic_ack_drop: got %b want 0", cpu_irq); end
        bus_rd(24'h002027, rd);
        n_cmp++;
        if (rd !== 8'h01) begin n_err++; $display("FAIL basic_ack_keeps_active: got %h want 01", rd); end
        raised = 0;
        for (int c = 0; c < 4 && !raised; c++) begin
            tick();
            if (cpu_irq === 1'b1) raised = 1;
        end
        n_cmp++;
        if (!raised) begin n_err++; $display("FAIL basic_reraise: got 0 want 1 within 4 cycles"); end
        n_cmp++;
        if (cpu_irq_vector !== 8'h08) begin n_err++; $display("FAIL basic_reraise_vec: got %h want 08", cpu_irq_vector); end
        bus_wr(24'h002027, 8'h01);
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL basic_clear_withdraw: got %b want 0", cpu_irq); end
    endtask

    task automatic test_tie_break();
        do_reset();
        cpu_irq_mask = 2'd0;
        bus_wr(24'h002020, 8'hFF);
        bus_wr(24'h002023, 8'hFF);
        bus_wr(24'h002024, 8'hFF);
        pulse_irq(16'h0024);
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b1) begin n_err++; $display("FAIL tie_raise: got %b want 1", cpu_irq); end
        n_cmp++;
        if (cpu_irq_vector !== 8'h0C) begin n_err++; $display("FAIL tie_vector: got %h want 0c", cpu_irq_vector); end
        pulse_irq(16'h0001);
        tick();
        n_cmp++;
        if (cpu_irq_vector !== 8'h0C || cpu_irq !== 1'b1) begin
            n_err++; $display("FAIL tie_no_rearb: got irq=%b vec=%h want irq=1 vec=0c", cpu_irq, cpu_irq_vector);
        end
    endtask

    task automatic test_group_priority();
        do_reset();
        cpu_irq_mask = 2'd0;
        bus_wr(24'h002020, 8'hC1);
        bus_wr(24'h002023, 8'hFF);
        bus_wr(24'h002024, 8'hFF);
        pulse_irq(16'h2002);
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b1) begin n_err++; $display("FAIL grp_raise: got %b want 1", cpu_irq); end
        n_cmp++;
        if (cpu_irq_vector !== 8'h22) begin n_err++; $display("FAIL grp_vector: got %h want 22", cpu_irq_vector); end
        cpu_irq_mask = 2'd3;
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL grp_mask_withdraw: got %b want 0", cpu_irq); end
        tick();
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL grp_mask_hold: got %b want 0", cpu_irq); end
        cpu_irq_mask = 2'd0;
        tick();
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b1 || cpu_irq_vector !== 8'h22) begin
            n_err++; $display("FAIL grp_unmask: got irq=%b vec=%h want irq=1 vec=22", cpu_irq, cpu_irq_vector);
        end
        cpu_irq_mask = 2'd0;
    endtask

    task automatic test_w1c();
        logic [7:0] rd;
        do_reset();
        pulse_irq(16'h0001);
        irq_in = 16'h0001;
        bus_wr(24'h002027, 8'h01);
        irq_in = 16'h0000;
        bus_rd(24'h002027, rd);
        n_cmp++;
        if (rd !== 8'h01) begin n_err++; $display("FAIL w1c_set_wins: got %h want 01", rd); end
        bus_wr(24'h002027, 8'h01);
        bus_rd(24'h002027, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL w1c_clear: got %h want 00", rd); end
        pulse_irq(16'h0200);
        bus_wr(24'h002028, 8'h00);
        bus_rd(24'h002028, rd);
        n_cmp++;
        if (rd !== 8'h02) begin n_err++; $display("FAIL w1c_zero_noop: got %h want 02", rd); end
        bus_wr(24'h002028, 8'h02);
        bus_rd(24'h002028, rd);
        n_cmp++;
        if (rd !== 8'h00) begin n_err++; $display("FAIL w1c_clear_hi: got %h want 00", rd); end
    endtask

    task automatic test_reset_mid_request();
        logic [7:0] rd;
        logic [23:0] addrs [5];
        addrs = '{24'h002020, 24'h002023, 24'h002024, 24'h002027, 24'h002028};
        do_reset();
        bus_wr(24'h002020, 8'h03);
        bus_wr(24'h002023, 8'h01);
        pulse_irq(16'h0001);
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b1) begin n_err++; $display("FAIL rstmid_pre: got %b want 1", cpu_irq); end
        reset  = 1'b1;
        irq_in = 16'hFFFF;
        bus_if.bus_address_in = 24'h002023;
        bus_if.bus_data_in    = 8'hFF;
        bus_if.bus_write      = 1'b1;
        tick();
        bus_if.bus_write = 1'b0;
        irq_in = 16'h0000;
        reset  = 1'b0;
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL rstmid_irq: got %b want 0", cpu_irq); end
        n_cmp++;
        if (cpu_irq_vector !== 8'h00) begin n_err++; $display("FAIL rstmid_vec: got %h want 00", cpu_irq_vector); end
        foreach (addrs[k]) begin
            bus_rd(addrs[k], rd);
            n_cmp++;
            if (rd !== 8'h00) begin n_err++; $display("FAIL rstmid_reg_%h: got %h want 00", addrs[k], rd); end
        end
        tick();
        tick();
        n_cmp++;
        if (cpu_irq !== 1'b0) begin n_err++; $display("FAIL rstmid_idle: got %b want 0", cpu_irq); end
    endtask

    task automatic test_disabled();
        logic [7:0] rd;
        bit seen;
        do_reset();
        cpu_irq_mask = 2'd0;
        bus_wr(24'h002020, 8'hFF);
        pulse_irq(16'h0008);
        bus_rd(24'h002027, rd);
        n_cmp++;
        if (rd !== 8'h08) begin n_err++; $display("FAIL dis_active: got %h want 08", rd); end
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            cpu_irq_ack = 1'b1;
            tick();
            if (cpu_irq !== 1'b0) seen = 1;
        end
        cpu_irq_ack = 1'b0;
        n_cmp++;
        if (seen) begin n_err++; $display("FAIL dis_no_irq: got 1 want 0"); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        irq_in = 16'h0000;
        cpu_irq_mask = 2'd0;
        cpu_irq_ack = 1'b0;
        bus_if.bus_write = 1'b0;
        bus_if.bus_read = 1'b0;
        bus_if.bus_address_in = 24'h000000;
        bus_if.bus_data_in = 8'h00;
        tick();
        test_reset();
        test_readback();
        test_basic_ack();
        test_tie_break();
        test_group_priority();
        test_w1c();
        test_reset_mid_request();
        test_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
